// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with EX operand forwarding and load-use hazard detection
//
// Captures the decoded instruction into the EX stage each cycle and presents forwarded ALU operands.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_*                            decoded instruction from ID (valid, operands, imm, shamt, aluop, regs, ctrl)
//   flush                           taken branch: squash the ID instruction
//   exmem_*, memwb_*                downstream write-back info used for forwarding
//   stall_o                         load-use hazard: hold PC and IF/ID this cycle
//   ex_valid, ex_in1, ex_in2        EX-stage valid and forwarded ALU operands
//   ex_store_data                   forwarded rt value for stores
//   ex_shamt, ex_aluop, ex_dst      registered shift amount, ALU op, destination register
//   ex_ctrl                         registered control bundle (same packing as id_ctrl)
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_shamt,
  input  logic [3:0]    id_aluop,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [7:0]    id_ctrl,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_dst,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_dst,
  input  logic [DW-1:0] memwb_result,
  output logic          stall_o,
  output logic          ex_valid,
  output logic [DW-1:0] ex_in1,
  output logic [DW-1:0] ex_in2,
  output logic [DW-1:0] ex_store_data,
  output logic [4:0]    ex_shamt,
  output logic [3:0]    ex_aluop,
  output logic [RW-1:0] ex_dst,
  output logic [7:0]    ex_ctrl
);

  // Control bundle bit positions: {reg_write,mem_read,mem_write,mem_to_reg,alu_src,reg_dst,branch,branch_ne}
  localparam int CTRL_MEM_READ = 6;
  localparam int CTRL_ALU_SRC  = 3;
  localparam int CTRL_REG_DST  = 2;

  logic          valid_q,   valid_d;
  logic [DW-1:0] rs_data_q, rs_data_d;
  logic [DW-1:0] rt_data_q, rt_data_d;
  logic [DW-1:0] imm_q,     imm_d;
  logic [4:0]    shamt_q,   shamt_d;
  logic [3:0]    aluop_q,   aluop_d;
  logic [RW-1:0] rs_q,      rs_d;
  logic [RW-1:0] rt_q,      rt_d;
  logic [RW-1:0] dst_q,     dst_d;
  logic [7:0]    ctrl_q,    ctrl_d;

  logic          haz;
  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;

  // A load in EX whose destination is read by the ID instruction cannot be forwarded in time.
  assign haz = valid_q & ctrl_q[CTRL_MEM_READ] & id_valid & (dst_q != '0) &
               ((dst_q == id_rs) | (dst_q == id_rt));

  // A flushed instruction is discarded, so holding it would be pointless.
  assign stall_o = haz & ~flush;

  always_comb begin
    valid_d   = id_valid;
    rs_data_d = id_rs_data;
    rt_data_d = id_rt_data;
    imm_d     = id_imm;
    shamt_d   = id_shamt;
    aluop_d   = id_aluop;
    rs_d      = id_rs;
    rt_d      = id_rt;
    dst_d     = id_ctrl[CTRL_REG_DST] ? id_rd : id_rt;
    ctrl_d    = id_valid ? id_ctrl : 8'h00;
    if (flush || haz) begin
      // Bubble: clearing rs/rt too keeps the empty slot from matching any forwarding source.
      valid_d   = 1'b0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      shamt_d   = '0;
      aluop_d   = '0;
      rs_d      = '0;
      rt_d      = '0;
      dst_d     = '0;
      ctrl_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      shamt_q   <= '0;
      aluop_q   <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      dst_q     <= '0;
      ctrl_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      shamt_q   <= shamt_d;
      aluop_q   <= aluop_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      dst_q     <= dst_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // EX/MEM holds the younger result, so it takes precedence over MEM/WB. $0 is never forwarded.
  always_comb begin
    fwd_a = rs_data_q;
    if (exmem_reg_write && (exmem_dst != '0) && (exmem_dst == rs_q)) begin
      fwd_a = exmem_result;
    end else if (memwb_reg_write && (memwb_dst != '0) && (memwb_dst == rs_q)) begin
      fwd_a = memwb_result;
    end
  end

  always_comb begin
    fwd_b = rt_data_q;
    if (exmem_reg_write && (exmem_dst != '0) && (exmem_dst == rt_q)) begin
      fwd_b = exmem_result;
    end else if (memwb_reg_write && (memwb_dst != '0) && (memwb_dst == rt_q)) begin
      fwd_b = memwb_result;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_in1        = fwd_a;
  assign ex_in2        = ctrl_q[CTRL_ALU_SRC] ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;
  assign ex_shamt      = shamt_q;
  assign ex_aluop      = aluop_q;
  assign ex_dst        = dst_q;
  assign ex_ctrl       = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt;
  logic [3:0]  id_aluop;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [7:0]  id_ctrl;
  logic        flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_dst;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_dst;
  logic [31:0] memwb_result;
  logic        stall_o;
  logic        ex_valid;
  logic [31:0] ex_in1, ex_in2, ex_store_data;
  logic [4:0]  ex_shamt;
  logic [3:0]  ex_aluop;
  logic [4:0]  ex_dst;
  logic [7:0]  ex_ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [7:0] CTRL_RTYPE = 8'h84; // reg_write, reg_dst
  localparam logic [7:0] CTRL_LW    = 8'hD8; // reg_write, mem_read, mem_to_reg, alu_src
  localparam logic [7:0] CTRL_ADDI  = 8'h88; // reg_write, alu_src

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_aluop(id_aluop),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_dst(exmem_dst), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_dst(memwb_dst), .memwb_result(memwb_result),
    .stall_o(stall_o), .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2),
    .ex_store_data(ex_store_data), .ex_shamt(ex_shamt), .ex_aluop(ex_aluop),
    .ex_dst(ex_dst), .ex_ctrl(ex_ctrl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a falling edge; one step crosses exactly one rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                          input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd,
                          input logic [31:0] imm, input logic [3:0] op, input logic [7:0] ctrl);
    id_valid   = v;
    id_rs      = rs;
    id_rs_data = rsd;
    id_rt      = rt;
    id_rt_data = rtd;
    id_rd      = rd;
    id_imm     = imm;
    id_aluop   = op;
    id_ctrl    = ctrl;
    id_shamt   = 5'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    exmem_reg_write = 1'b0; exmem_dst = 5'd0; exmem_result = 32'h0;
    memwb_reg_write = 1'b0; memwb_dst = 5'd0; memwb_result = 32'h0;
    drive_id(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 4'h0, 8'h00);
    step();
    check("reset_valid", {31'b0, ex_valid}, 32'h0);
    check("reset_ctrl", {24'b0, ex_ctrl}, 32'h0);
    check("reset_in1", ex_in1, 32'h0);
    check("reset_stall", {31'b0, stall_o}, 32'h0);
    rst_n = 1'b1;

    // Pass-through: add $3 = $1(5) + $2(7)
    drive_id(1'b1, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'h0, 4'b0010, CTRL_RTYPE);
    id_shamt = 5'd9;
    step();
    check("pt_valid", {31'b0, ex_valid}, 32'h1);
    check("pt_in1", ex_in1, 32'd5);
    check("pt_in2", ex_in2, 32'd7);
    check("pt_dst", {27'b0, ex_dst}, 32'd3);
    check("pt_aluop", {28'b0, ex_aluop}, 32'h2);
    check("pt_shamt", {27'b0, ex_shamt}, 32'd9);
    check("pt_ctrl", {24'b0, ex_ctrl}, {24'b0, CTRL_RTYPE});

    // Invalid ID slot: control masked to zero
    drive_id(1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'h0, 4'b0010, CTRL_RTYPE);
    step();
    check("inv_valid", {31'b0, ex_valid}, 32'h0);
    check("inv_ctrl", {24'b0, ex_ctrl}, 32'h0);

    // Forward priority on rs=4; rt=5 untouched until memwb targets it
    drive_id(1'b1, 5'd4, 32'h11, 5'd5, 32'h22, 5'd6, 32'h0, 4'b0110, CTRL_RTYPE);
    step();
    exmem_reg_write = 1'b1; exmem_dst = 5'd4; exmem_result = 32'hAA;
    memwb_reg_write = 1'b1; memwb_dst = 5'd4; memwb_result = 32'hBB;
    #1;
    check("fwd_exmem_wins", ex_in1, 32'hAA);
    check("fwd_b_none", ex_in2, 32'h22);
    exmem_reg_write = 1'b0;
    #1;
    check("fwd_memwb", ex_in1, 32'hBB);
    memwb_dst = 5'd5;
    #1;
    check("fwd_memwb_rs_released", ex_in1, 32'h11);
    check("fwd_b_memwb", ex_in2, 32'hBB);
    check("fwd_b_store", ex_store_data, 32'hBB);
    memwb_reg_write = 1'b0;

    // alu_src picks imm for In2 while store data still forwards rt
    drive_id(1'b1, 5'd4, 32'h11, 5'd5, 32'h22, 5'd6, 32'h1234, 4'b0010, CTRL_ADDI);
    step();
    exmem_reg_write = 1'b1; exmem_dst = 5'd5; exmem_result = 32'hCC;
    #1;
    check("imm_in2", ex_in2, 32'h1234);
    check("imm_store_fwd", ex_store_data, 32'hCC);
    check("imm_dst_rt", {27'b0, ex_dst}, 32'd5);
    exmem_reg_write = 1'b0;

    // $0 guard
    drive_id(1'b1, 5'd0, 32'h0, 5'd2, 32'd7, 5'd3, 32'h0, 4'b0010, CTRL_RTYPE);
    step();
    exmem_reg_write = 1'b1; exmem_dst = 5'd0; exmem_result = 32'h55;
    #1;
    check("zero_guard", ex_in1, 32'h0);
    exmem_reg_write = 1'b0;

    // Load-use: lw $8, 4($9) then add $10 = $8 + $2
    drive_id(1'b1, 5'd9, 32'h100, 5'd8, 32'h0, 5'd0, 32'd4, 4'b0010, CTRL_LW);
    step();
    check("lw_dst", {27'b0, ex_dst}, 32'd8);
    drive_id(1'b1, 5'd8, 32'h0, 5'd2, 32'd7, 5'd10, 32'h0, 4'b0010, CTRL_RTYPE);
    #1;
    check("lu_stall", {31'b0, stall_o}, 32'h1);
    step();
    check("lu_bubble_valid", {31'b0, ex_valid}, 32'h0);
    check("lu_bubble_ctrl", {24'b0, ex_ctrl}, 32'h0);
    check("lu_stall_released", {31'b0, stall_o}, 32'h0);
    step();
    memwb_reg_write = 1'b1; memwb_dst = 5'd8; memwb_result = 32'hDEAD;
    #1;
    check("lu_add_valid", {31'b0, ex_valid}, 32'h1);
    check("lu_add_fwd", ex_in1, 32'hDEAD);
    check("lu_add_dst", {27'b0, ex_dst}, 32'd10);
    memwb_reg_write = 1'b0;

    // Flush while a load-use hazard is present
    drive_id(1'b1, 5'd9, 32'h100, 5'd8, 32'h0, 5'd0, 32'd4, 4'b0010, CTRL_LW);
    step();
    drive_id(1'b1, 5'd8, 32'h0, 5'd2, 32'd7, 5'd10, 32'h0, 4'b0010, CTRL_RTYPE);
    flush = 1'b1;
    #1;
    check("flush_no_stall", {31'b0, stall_o}, 32'h0);
    step();
    flush = 1'b0;
    check("flush_valid", {31'b0, ex_valid}, 32'h0);
    check("flush_ctrl", {24'b0, ex_ctrl}, 32'h0);
    check("flush_dst", {27'b0, ex_dst}, 32'h0);

    // Asynchronous reset mid-stall
    drive_id(1'b1, 5'd9, 32'h100, 5'd8, 32'h0, 5'd0, 32'd4, 4'b0010, CTRL_LW);
    step();
    drive_id(1'b1, 5'd8, 32'h0, 5'd2, 32'd7, 5'd10, 32'h0, 4'b0010, CTRL_RTYPE);
    #1;
    check("pre_reset_stall", {31'b0, stall_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_valid", {31'b0, ex_valid}, 32'h0);
    check("async_stall", {31'b0, stall_o}, 32'h0);
    check("async_ctrl", {24'b0, ex_ctrl}, 32'h0);
    check("async_in1", ex_in1, 32'h0);
    check("async_in2", ex_in2, 32'h0);
    check("async_store", ex_store_data, 32'h0);
    check("async_dst", {27'b0, ex_dst}, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
